// File: rtl/timer_clk_div.sv
// Prescaler ahead of the timer counter: divides pclk by 2^(clk_sel+1) and emits a one-cycle cnt_tick.
// A divisor change waits for the next tick boundary of the old divisor, so no short period is ever produced.
module timer_clk_div #(
  parameter int SEL_W = 2,
  parameter int DIV_W = 4
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             en,
  input  logic             halt,
  input  logic [SEL_W-1:0] clk_sel,
  output logic             cnt_tick,
  output logic [SEL_W-1:0] active_sel,
  output logic             sel_pending,
  output logic [DIV_W-1:0] div_phase
);

  logic [DIV_W-1:0] phase_q, phase_d;
  logic             tick_q, tick_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             pend_q, pend_d;
  logic             en_q;

  logic             start;
  logic [SEL_W-1:0] cur_sel;
  logic [DIV_W-1:0] mask;
  logic             at_bound;

  // On the first enabled edge, a clk_sel written together with en takes effect at once.
  assign start    = en & ~en_q;
  assign cur_sel  = start ? clk_sel : sel_q;
  assign mask     = DIV_W'((32'd2 << cur_sel) - 32'd1);
  assign at_bound = (phase_q & mask) == mask;

  always_comb begin
    phase_d = phase_q;
    tick_d  = 1'b0;
    sel_d   = sel_q;
    pend_d  = pend_q;
    if (!en) begin
      phase_d = '0;
      sel_d   = clk_sel;
      pend_d  = 1'b0;
    end else begin
      sel_d  = cur_sel;
      pend_d = (clk_sel != cur_sel);
      if (!halt) begin
        tick_d = at_bound;
        if (at_bound && pend_d) begin
          sel_d   = clk_sel;
          phase_d = '0;
          pend_d  = 1'b0;
        end else begin
          phase_d = phase_q + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      phase_q <= '0;
      tick_q  <= 1'b0;
      sel_q   <= '0;
      pend_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      tick_q  <= tick_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      en_q    <= en;
    end
  end

  assign cnt_tick    = tick_q;
  assign active_sel  = sel_q;
  assign sel_pending = pend_q;
  assign div_phase   = phase_q;

endmodule

// File: tb/tb_timer_clk_div.sv
// Randomized and directed bench for timer_clk_div against a count-based reference model.
module tb_timer_clk_div;

  logic       pclk = 1'b0;
  logic       preset, en, halt;
  logic [1:0] clk_sel;
  logic       cnt_tick;
  logic [1:0] active_sel;
  logic       sel_pending;
  logic [3:0] div_phase;

  timer_clk_div dut (
    .pclk       (pclk),
    .preset     (preset),
    .en         (en),
    .halt       (halt),
    .clk_sel    (clk_sel),
    .cnt_tick   (cnt_tick),
    .active_sel (active_sel),
    .sel_pending(sel_pending),
    .div_phase  (div_phase)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Model: run cycles elapsed since the period origin, plus the divisor in force.
  int m_cnt  = 0;
  int m_act  = 0;
  bit m_pend = 0;
  bit m_tick = 0;
  bit m_en_prev = 0;

  function automatic void model_step(input bit r, input bit e, input bit h, input int s);
    int n;
    if (r) begin
      m_cnt = 0; m_tick = 0; m_act = 0; m_pend = 0; m_en_prev = 0;
      return;
    end
    if (!e) begin
      m_cnt = 0; m_tick = 0; m_act = s; m_pend = 0;
    end else begin
      if (!m_en_prev) m_act = s;
      n = 2 ** (m_act + 1);
      if (h) begin
        m_tick = 0;
        m_pend = (s != m_act);
      end else begin
        m_tick = ((m_cnt % n) == n - 1);
        if (m_tick && s != m_act) begin
          m_act = s; m_cnt = 0; m_pend = 0;
        end else begin
          m_cnt++;
          m_pend = (s != m_act);
        end
      end
    end
    m_en_prev = e;
  endfunction

  int cyc_n = 0, last_tick = 0, last_gap = 0, tick_total = 0;
  bit prev_tick_obs = 0;

  task automatic cyc(input bit r, input bit e, input bit h, input logic [1:0] s);
    preset = r; en = e; halt = h; clk_sel = s;
    model_step(r, e, h, int'(s));
    @(negedge pclk);
    cyc_n++;
    check_eq("cnt_tick", {31'b0, cnt_tick}, {31'b0, m_tick});
    check_eq("active_sel", {30'b0, active_sel}, m_act);
    check_eq("sel_pending", {31'b0, sel_pending}, {31'b0, m_pend});
    check_eq("div_phase", {28'b0, div_phase}, m_cnt % 16);
    check_eq("no_back_to_back", {31'b0, prev_tick_obs & cnt_tick}, 0);
    if (cnt_tick === 1'b1) begin
      tick_total++;
      last_gap  = cyc_n - last_tick;
      last_tick = cyc_n;
    end
    prev_tick_obs = (cnt_tick === 1'b1);
  endtask

  initial begin
    int first;
    int base;
    int t0;
    bit r, e, h;
    logic [1:0] s;

    // 1: reset, then /8 from enable
    cyc(1, 0, 0, 2'd0);
    cyc(1, 0, 0, 2'd2);
    check_eq("reset_phase", {28'b0, div_phase}, 0);
    check_eq("reset_active", {30'b0, active_sel}, 0);
    tick_total = 0;
    first = -1;
    for (int i = 0; i < 2048; i++) begin
      cyc(0, 1, 0, 2'd2);
      if (first < 0 && cnt_tick === 1'b1) first = i + 1;
      if (i == 1759) check_eq("t1_220_ticks", tick_total, 220);
    end
    check_eq("t1_first_tick", first, 8);
    check_eq("t1_256_ticks", tick_total, 256);

    // 2: /2 and /16 from a fresh enable
    for (int k = 0; k < 2; k++) begin
      s = (k == 0) ? 2'd0 : 2'd3;
      cyc(0, 0, 0, s);
      tick_total = 0;
      for (int i = 0; i < 64; i++) cyc(0, 1, 0, s);
      check_eq("t2_tick_count", tick_total, (k == 0) ? 32 : 4);
      check_eq("t2_period", last_gap, (k == 0) ? 2 : 16);
      check_eq("t2_active", {30'b0, active_sel}, {30'b0, s});
    end

    // 3: /8 running, switch to /2 at phase 3
    cyc(0, 0, 0, 2'd2);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 2'd2);
    for (int i = 0; i < 16 && (m_cnt % 8) != 3; i++) cyc(0, 1, 0, 2'd2);
    t0 = tick_total;
    for (int i = 0; i < 20 && tick_total == t0; i++) cyc(0, 1, 0, 2'd0);
    check_eq("t3_boundary_gap", last_gap, 8);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 2'd0);
    check_eq("t3_new_period", last_gap, 2);

    // 4: drop en at phase 5, re-enable
    cyc(0, 0, 0, 2'd2);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 2'd2);
    for (int i = 0; i < 16 && (m_cnt % 8) != 5; i++) cyc(0, 1, 0, 2'd2);
    cyc(0, 0, 0, 2'd2);
    check_eq("t4_no_tick", {31'b0, cnt_tick}, 0);
    check_eq("t4_phase0", {28'b0, div_phase}, 0);
    base = cyc_n;
    t0 = tick_total;
    for (int i = 0; i < 20 && tick_total == t0; i++) cyc(0, 1, 0, 2'd2);
    check_eq("t4_first_tick", cyc_n - base, 8);

    // 5: halt 10 cycles at phase 3
    for (int i = 0; i < 16 && (m_cnt % 8) != 3; i++) cyc(0, 1, 0, 2'd2);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 2'd2);
    t0 = tick_total;
    for (int i = 0; i < 30 && tick_total == t0; i++) cyc(0, 1, 0, 2'd2);
    check_eq("t5_halt_gap", last_gap, 18);

    // 6: reset mid-period at /16
    cyc(0, 0, 0, 2'd3);
    for (int i = 0; i < 40; i++) cyc(0, 1, 0, 2'd3);
    for (int i = 0; i < 16 && (m_cnt % 16) != 9; i++) cyc(0, 1, 0, 2'd3);
    cyc(1, 1, 0, 2'd3);
    check_eq("t6_tick", {31'b0, cnt_tick}, 0);
    check_eq("t6_active", {30'b0, active_sel}, 0);
    check_eq("t6_pending", {31'b0, sel_pending}, 0);
    check_eq("t6_phase", {28'b0, div_phase}, 0);

    // Random traffic
    s = 2'd1;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 63) == 0);
      e = ($urandom_range(0, 7) != 0);
      h = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) s = 2'($urandom_range(0, 3));
      cyc(r, e, h, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
